// File: rtl/vid_tim_gen_if.sv
// rtl/vid_tim_gen_if.sv - control, timing and video output bundle for vid_tim_gen
//
// Purpose: groups every non-clock/reset signal of the raster timing generator.
// Ports (all carried as interface members):
//   ena, buf_swap, free_run, hpol, vpol        control inputs to the generator
//   Thsync, Thgdel, Thgate, Thlen  [HW-1:0]    horizontal timing, each value minus one
//   Tvsync, Tvgdel, Tvgate, Tvlen  [VW-1:0]    vertical timing, each value minus one
//   hsync, vsync, daten, frame_start, busy     registered video outputs
// Modports: master = generator side, slave = frame-buffer / pixel-stage side.

interface vid_tim_gen_if #(
  parameter int HW = 16,
  parameter int VW = 12
);
  logic          ena;
  logic          buf_swap;
  logic          free_run;
  logic          hpol;
  logic          vpol;
  logic [HW-1:0] Thsync;
  logic [HW-1:0] Thgdel;
  logic [HW-1:0] Thgate;
  logic [HW-1:0] Thlen;
  logic [VW-1:0] Tvsync;
  logic [VW-1:0] Tvgdel;
  logic [VW-1:0] Tvgate;
  logic [VW-1:0] Tvlen;
  logic          hsync;
  logic          vsync;
  logic          daten;
  logic          frame_start;
  logic          busy;

  modport master (
    input  ena, buf_swap, free_run, hpol, vpol,
    input  Thsync, Thgdel, Thgate, Thlen, Tvsync, Tvgdel, Tvgate, Tvlen,
    output hsync, vsync, daten, frame_start, busy
  );

  modport slave (
    output ena, buf_swap, free_run, hpol, vpol,
    output Thsync, Thgdel, Thgate, Thlen, Tvsync, Tvgdel, Tvgate, Tvlen,
    input  hsync, vsync, daten, frame_start, busy
  );
endinterface

// File: rtl/vid_tim_gen.sv
// rtl/vid_tim_gen.sv - programmable H+V raster timing generator with one-shot / free-run frames
//
// Purpose: generates hsync/vsync/daten/frame_start for one frame per buf_swap rising edge,
//   or continuously while free_run is high. Timing is captured into shadows at each frame start.
// Ports:
//   clk    in  pixel clock
//   rst_n  in  asynchronous active-low reset
//   vif    vid_tim_gen_if.master: ena, buf_swap (async), free_run, hpol, vpol, T* timing in;
//          hsync, vsync, daten, frame_start, busy out (registered)

module vid_tim_gen #(
  parameter int HW          = 16,
  parameter int VW          = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vid_tim_gen_if.master     vif
);

  // Two guard bits keep start/end sums from ever wrapping.
  localparam int HX = HW + 2;
  localparam int VX = VW + 2;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_nxt;
  logic                   load;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   swap_d;
  logic                   swap_pend;
  logic                   swap_rise;

  logic [HW-1:0]          hcnt;
  logic [VW-1:0]          vcnt;
  logic [HW-1:0]          thsync_s, thgdel_s, thgate_s, thlen_s;
  logic [VW-1:0]          tvsync_s, tvgdel_s, tvgate_s, tvlen_s;

  logic                   line_end, frame_end;
  logic [HX-1:0]          hgs, hge;
  logic [VX-1:0]          vgs, vge;
  logic                   hs, vs, hg, vg;

  assign swap_rise = sync_q[SYNC_STAGES-1] & ~swap_d;
  assign line_end  = (hcnt == thlen_s);
  assign frame_end = line_end & (vcnt == tvlen_s);

  assign hgs = HX'(thsync_s) + HX'(thgdel_s) + HX'(2);
  assign hge = hgs + HX'(thgate_s);
  assign vgs = VX'(tvsync_s) + VX'(tvgdel_s) + VX'(2);
  assign vge = vgs + VX'(tvgate_s);

  assign hs = (hcnt <= thsync_s);
  assign vs = (vcnt <= tvsync_s);
  assign hg = (HX'(hcnt) >= hgs) && (HX'(hcnt) <= hge);
  assign vg = (VX'(vcnt) >= vgs) && (VX'(vcnt) <= vge);

  // buf_swap synchroniser and edge detector; not gated by ena so requests are never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      swap_d    <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vif.buf_swap};
      swap_d <= sync_q[SYNC_STAGES-1];
      // A new edge in the same cycle as consumption must survive, so set wins.
      if (swap_rise)
        swap_pend <= 1'b1;
      else if (load)
        swap_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // load marks a frame start: either from IDLE or a back-to-back restart at end of frame.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (vif.ena && (swap_pend || vif.free_run)) begin
          state_nxt = ACTIVE;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (vif.ena && frame_end) begin
          if (vif.free_run || swap_pend)
            load = 1'b1;
          else
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      vcnt     <= '0;
      thsync_s <= '0;
      thgdel_s <= '0;
      thgate_s <= '0;
      thlen_s  <= '0;
      tvsync_s <= '0;
      tvgdel_s <= '0;
      tvgate_s <= '0;
      tvlen_s  <= '0;
    end else if (load) begin
      hcnt     <= '0;
      vcnt     <= '0;
      thsync_s <= vif.Thsync;
      thgdel_s <= vif.Thgdel;
      thgate_s <= vif.Thgate;
      thlen_s  <= vif.Thlen;
      tvsync_s <= vif.Tvsync;
      tvgdel_s <= vif.Tvgdel;
      tvgate_s <= vif.Tvgate;
      tvlen_s  <= vif.Tvlen;
    end else if (vif.ena && state == ACTIVE) begin
      if (line_end) begin
        hcnt <= '0;
        vcnt <= frame_end ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Output stage: one clock behind the counters; idle level is the inactive sync level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vif.hsync       <= 1'b0;
      vif.vsync       <= 1'b0;
      vif.daten       <= 1'b0;
      vif.frame_start <= 1'b0;
      vif.busy        <= 1'b0;
    end else if (vif.ena) begin
      if (state == ACTIVE) begin
        vif.hsync       <= hs ^ vif.hpol;
        vif.vsync       <= vs ^ vif.vpol;
        vif.daten       <= hg & vg;
        vif.frame_start <= (hcnt == '0) && (vcnt == '0);
        vif.busy        <= 1'b1;
      end else begin
        vif.hsync       <= vif.hpol;
        vif.vsync       <= vif.vpol;
        vif.daten       <= 1'b0;
        vif.frame_start <= 1'b0;
        vif.busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vid_tim_gen.sv
// tb/tb_vid_tim_gen.sv - scoreboard testbench for vid_tim_gen

module tb_vid_tim_gen;

  localparam int HW = 16;
  localparam int VW = 12;

  logic clk;
  logic rst_n;

  vid_tim_gen_if #(.HW(HW), .VW(VW)) vif ();

  vid_tim_gen #(.HW(HW), .VW(VW), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int hsp;
    int hsa;
    int vsa;
    int de;
  } frm_t;

  frm_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int len, input int hsp, input int hsa, input int vsa, input int de);
    frm_t f;
    f.len = len; f.hsp = hsp; f.hsa = hsa; f.vsa = vsa; f.de = de;
    exp_q.push_back(f);
  endtask

  task automatic close_frame(input frm_t got);
    frm_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL frame_unexpected: got len %0d expected no frame", got.len);
    end else begin
      e = exp_q.pop_front();
      check("frame_len",   got.len, e.len);
      check("hsync_pulses", got.hsp, e.hsp);
      check("hsync_active", got.hsa, e.hsa);
      check("vsync_active", got.vsa, e.vsa);
      check("daten_cycles", got.de,  e.de);
    end
  endtask

  // Monitor: a frame runs from a frame_start rise until the next rise or until busy drops.
  initial begin : monitor
    frm_t cur;
    bit   in_f, pfs, phs, ah;
    in_f = 0; pfs = 0; phs = 0;
    cur = '{0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_f = 0;
        pfs  = 0;
      end else begin
        if (vif.frame_start && !pfs) begin
          if (in_f) close_frame(cur);
          cur  = '{0, 0, 0, 0, 0};
          in_f = 1;
          phs  = 0;
        end
        pfs = vif.frame_start;
        if (in_f) begin
          if (vif.busy) begin
            ah = vif.hsync ^ vif.hpol;
            cur.len++;
            if (ah) cur.hsa++;
            if (ah && !phs) cur.hsp++;
            phs = ah;
            if (vif.vsync ^ vif.vpol) cur.vsa++;
            if (vif.daten) cur.de++;
          end else begin
            close_frame(cur);
            in_f = 0;
          end
        end
      end
    end
  end

  task automatic pulse_swap();
    vif.buf_swap = 1'b1;
    repeat (2) @(negedge clk);
    vif.buf_swap = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_fs(input string nm, input int bound);
    bit seen;
    seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (vif.frame_start) seen = 1;
    end
    check(nm, seen, 1);
  endtask

  task automatic wait_idle(input string nm, input int bound);
    bit idle;
    idle = 0;
    for (int i = 0; i < bound && !idle; i++) begin
      @(negedge clk);
      if (!vif.busy) idle = 1;
    end
    check(nm, idle, 1);
  endtask

  task automatic cfg_a();
    vif.Thsync = 16'd1; vif.Thgdel = 16'd0; vif.Thgate = 16'd3; vif.Thlen = 16'd9;
    vif.Tvsync = 12'd0; vif.Tvgdel = 12'd0; vif.Tvgate = 12'd1; vif.Tvlen = 12'd4;
  endtask

  initial begin : stim
    bit seen_busy;
    rst_n        = 1'b0;
    vif.ena      = 1'b1;
    vif.buf_swap = 1'b0;
    vif.free_run = 1'b0;
    vif.hpol     = 1'b0;
    vif.vpol     = 1'b0;
    cfg_a();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {vif.hsync, vif.vsync, vif.daten, vif.frame_start, vif.busy}, 5'b00000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_request", vif.busy, 0);

    // One-shot frame with latency measurement: buf_swap high before E0, frame_start after E4
    push(50, 5, 10, 10, 8);
    vif.buf_swap = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("latency_e3_fs", vif.frame_start, 0);
    @(posedge clk);
    #1 check("latency_e4_fs", vif.frame_start, 1);
    check("latency_e4_hsync", vif.hsync, 1);
    @(posedge clk);
    #1 check("fs_one_cycle", vif.frame_start, 0);
    @(negedge clk);
    vif.buf_swap = 1'b0;
    wait_idle("t1_idle", 200);
    repeat (2) @(negedge clk);
    check("t1_idle_outputs", {vif.hsync, vif.vsync, vif.daten, vif.busy}, 4'b0000);

    // Three extra edges during a frame coalesce into exactly one more frame
    push(50, 5, 10, 10, 8);
    push(50, 5, 10, 10, 8);
    pulse_swap();
    wait_fs("t2_start", 20);
    repeat (8) @(negedge clk);
    repeat (3) pulse_swap();
    wait_idle("t2_idle", 300);
    repeat (20) @(negedge clk);
    check("t2_no_third_frame", vif.busy, 0);

    // Free-run; Thgate change mid-frame applies to the following frame only
    push(50, 5, 10, 10, 8);
    push(50, 5, 10, 10, 4);
    vif.free_run = 1'b1;
    wait_fs("t3_start", 20);
    repeat (20) @(negedge clk);
    vif.Thgate = 16'd1;
    wait_fs("t3_second", 60);
    repeat (5) @(negedge clk);
    vif.free_run = 1'b0;
    wait_idle("t3_idle", 200);
    vif.Thgate = 16'd3;

    // ena toggling every cycle halves the rate
    push(100, 5, 20, 20, 16);
    vif.buf_swap = 1'b1;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      vif.ena = ~vif.ena;
      if (i == 6) vif.buf_swap = 1'b0;
    end
    vif.ena = 1'b1;
    wait_idle("t4_idle", 300);

    // Inverted polarity; gate start beyond line length
    vif.hpol = 1'b1; vif.vpol = 1'b1; vif.Thgdel = 16'd8;
    repeat (2) @(negedge clk);
    push(50, 5, 10, 10, 0);
    pulse_swap();
    wait_fs("t5_start", 20);
    wait_idle("t5_idle", 200);
    repeat (2) @(negedge clk);
    check("t5_idle_sync_inv", {vif.hsync, vif.vsync, vif.daten}, 3'b110);
    vif.hpol = 1'b0; vif.vpol = 1'b0; vif.Thgdel = 16'd0;

    // Asynchronous reset mid-frame (line 2), then idle until a new request
    pulse_swap();
    wait_fs("t6_start", 20);
    repeat (22) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset", {vif.hsync, vif.vsync, vif.daten, vif.frame_start, vif.busy}, 5'b00000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen_busy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vif.busy) seen_busy = 1;
    end
    check("t6_stays_idle", seen_busy, 0);
    push(50, 5, 10, 10, 8);
    pulse_swap();
    wait_fs("t6_restart", 20);
    wait_idle("t6_idle", 200);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
